// File: rtl/seven_segment_pkg.sv
// Shared definitions for the integer seven-segment display driver:
// conversion FSM states, segment bit order and common-anode glyphs.
package seven_segment_pkg;

    // Conversion FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } conv_state_t;

    // Segment vector bit order is {dp,g,f,e,d,c,b,a}; dp sits in the MSB.
    localparam int SEG_WIDTH  = 8;
    localparam int SEG_DP_BIT = 7;

    // Active-low glyphs for a common-anode display (0 = segment lit).
    localparam logic [SEG_WIDTH-1:0] GLYPH_0     = 8'hC0;
    localparam logic [SEG_WIDTH-1:0] GLYPH_1     = 8'hF9;
    localparam logic [SEG_WIDTH-1:0] GLYPH_2     = 8'hA4;
    localparam logic [SEG_WIDTH-1:0] GLYPH_3     = 8'hB0;
    localparam logic [SEG_WIDTH-1:0] GLYPH_4     = 8'h99;
    localparam logic [SEG_WIDTH-1:0] GLYPH_5     = 8'h92;
    localparam logic [SEG_WIDTH-1:0] GLYPH_6     = 8'h82;
    localparam logic [SEG_WIDTH-1:0] GLYPH_7     = 8'hF8;
    localparam logic [SEG_WIDTH-1:0] GLYPH_8     = 8'h80;
    localparam logic [SEG_WIDTH-1:0] GLYPH_9     = 8'h90;
    localparam logic [SEG_WIDTH-1:0] GLYPH_BLANK = 8'hFF;
    localparam logic [SEG_WIDTH-1:0] GLYPH_DASH  = 8'hBF;

    // Map a BCD nibble to its glyph; non-decimal codes render blank.
    function automatic logic [SEG_WIDTH-1:0] glyph_of(input logic [3:0] nibble);
        logic [SEG_WIDTH-1:0] g;
        case (nibble)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // 10^n, evaluated at elaboration time for the overflow threshold.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/binary_to_bcd.sv
// Sequential shift-and-add-3 binary to BCD converter.
// Handshake: i_start is honoured only in IDLE (o_busy low); o_done pulses
// for the single COMMIT cycle, during which o_bcd and o_overflow are valid.
// Values at or above 10^digits skip conversion and commit with o_overflow set.
module binary_to_bcd
    import seven_segment_pkg::*;
#(
    parameter int value_width = 14,
    parameter int digits      = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [value_width-1:0] i_value,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [4*digits-1:0]    o_bcd,
    output logic                   o_overflow,
    output logic [1:0]             o_state
);

    localparam int                BCD_W     = 4 * digits;
    localparam int                ITER_W    = $clog2(value_width + 1);
    localparam logic [63:0]       LIMIT     = pow10(digits);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(value_width - 1);

    conv_state_t            r_state;
    conv_state_t            w_state_next;
    logic [value_width-1:0] r_bin;
    logic [BCD_W-1:0]       r_bcd;
    logic [BCD_W-1:0]       w_bcd_adj;
    logic [ITER_W-1:0]      r_iter;
    logic                   r_ovf;
    logic                   w_too_big;
    logic                   w_last_iter;

    assign w_too_big   = (64'(i_value) >= LIMIT);
    assign w_last_iter = (r_iter == LAST_ITER);

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: out-of-range values bypass the shift loop.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = w_too_big ? ST_COMMIT : ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (w_last_iter) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        o_busy  = (r_state != ST_IDLE);
        o_done  = (r_state == ST_COMMIT);
        o_state = r_state;
    end

    // Add 3 to every nibble >= 5 so the following shift carries correctly.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < digits; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Datapath: capture on start, then shift {bcd, bin} left once per cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_iter <= '0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_bin  <= i_value;
                        r_bcd  <= '0;
                        r_iter <= '0;
                        r_ovf  <= w_too_big;
                    end
                end
                ST_CONVERT: begin
                    r_bcd  <= {w_bcd_adj[BCD_W-2:0], r_bin[value_width-1]};
                    r_bin  <= {r_bin[value_width-2:0], 1'b0};
                    r_iter <= r_iter + ITER_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign o_bcd      = r_bcd;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/integer_seven_segment_display_driver.sv
// Integer to multiplexed common-anode seven-segment display driver.
// Holds the display register, the free-running digit scanner, leading-zero
// blanking and glyph decode; conversion is delegated to binary_to_bcd.
// Load handshake: i_load is a one-cycle strobe accepted only while o_busy
// is low; strobes seen while o_busy is high are discarded.
module integer_seven_segment_display_driver
    import seven_segment_pkg::*;
#(
    parameter int digits       = 4,
    parameter int value_width  = 14,
    parameter int digit_period = 100000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [value_width-1:0] i_value,
    input  logic                   i_load,
    output logic                   o_busy,
    output logic                   o_overflow,
    output logic [digits-1:0]      o_anode,
    output logic [7:0]             o_segment,
    output logic [1:0]             o_dbg_state
);

    localparam int                BCD_W    = 4 * digits;
    localparam int                IDX_W    = (digits > 1) ? $clog2(digits) : 1;
    localparam int                CNT_W    = (digit_period > 1) ? $clog2(digit_period) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(digits - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(digit_period - 1);

    logic                 w_busy;
    logic                 w_done;
    logic [BCD_W-1:0]     w_bcd;
    logic                 w_bcd_ovf;
    logic [1:0]           w_conv_state;

    logic [BCD_W-1:0]     r_display;
    logic                 r_overflow;
    logic [CNT_W-1:0]     r_scan_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [digits-1:0]    r_anode;
    logic [SEG_WIDTH-1:0] r_segment;

    logic [BCD_W-1:0]     w_disp_next;
    logic                 w_ovf_next;
    logic                 w_scan_tc;
    logic [IDX_W-1:0]     w_idx_next;
    logic [3:0]           w_nibble;
    logic                 w_blank;
    logic [SEG_WIDTH-1:0] w_seg_next;
    logic [digits-1:0]    w_anode_next;

    binary_to_bcd #(
        .value_width (value_width),
        .digits      (digits)
    ) u_binary_to_bcd (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_load),
        .i_value    (i_value),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_bcd      (w_bcd),
        .o_overflow (w_bcd_ovf),
        .o_state    (w_conv_state)
    );

    // Next display contents: replaced only on the COMMIT cycle.
    always_comb begin
        w_disp_next = r_display;
        w_ovf_next  = r_overflow;
        if (w_done) begin
            w_disp_next = w_bcd_ovf ? '0 : w_bcd;
            w_ovf_next  = w_bcd_ovf;
        end
    end

    // Next digit index: advance at the scan terminal count, wrapping to 0.
    always_comb begin
        w_scan_tc  = (r_scan_cnt == LAST_CNT);
        w_idx_next = r_idx;
        if (w_scan_tc) begin
            w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Glyph for the digit lit next cycle, from the next display contents so
    // a commit and a digit advance on the same edge stay consistent.
    always_comb begin
        w_nibble = w_disp_next[4*w_idx_next +: 4];
        // A digit above 0 is blanked unless some nibble at or above it is non-zero.
        w_blank  = (w_idx_next != '0);
        for (int i = 0; i < digits; i++) begin
            if ((i >= int'(w_idx_next)) && (w_disp_next[4*i +: 4] != 4'd0)) begin
                w_blank = 1'b0;
            end
        end
        if (w_ovf_next) begin
            w_seg_next = GLYPH_DASH;
        end else if (w_blank) begin
            w_seg_next = GLYPH_BLANK;
        end else begin
            w_seg_next = glyph_of(w_nibble);
        end
        w_seg_next[SEG_DP_BIT] = 1'b1;
        w_anode_next = ~(digits'(1) << w_idx_next);
    end

    // Display register and overflow flag.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_display  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_display  <= w_disp_next;
            r_overflow <= w_ovf_next;
        end
    end

    // Free-running scan counter and digit index.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else begin
            r_scan_cnt <= w_scan_tc ? '0 : r_scan_cnt + CNT_W'(1);
            r_idx      <= w_idx_next;
        end
    end

    // Anode and segment registered together so they switch on the same edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_anode   <= '1;
            r_segment <= GLYPH_BLANK;
        end else begin
            r_anode   <= w_anode_next;
            r_segment <= w_seg_next;
        end
    end

    assign o_busy      = w_busy;
    assign o_overflow  = r_overflow;
    assign o_anode     = r_anode;
    assign o_segment   = r_segment;
    assign o_dbg_state = w_conv_state;

endmodule

// File: doc/integer_seven_segment_display_driver.md
# integer_seven_segment_display_driver

Converts an unsigned binary integer into decimal and drives a time-multiplexed, common-anode seven-segment display. It sits downstream of the debounced push-button reset controller, whose active-low reset it consumes. It receives the integer from the application datapath through a single-cycle load strobe. Conversion is sequential (shift-and-add-3), and digit scanning runs continuously and independently of conversion.

## Interface
- `digits`, default 4: number of display digits.
- `value_width`, default 14: width of `value`.
- `digit_period`, default 100000: clock cycles each digit stays lit (1 ms at 100 MHz).
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `value`  in  `value_width`: unsigned integer, sampled on `load`.
- `load`  in  1: single-cycle strobe requesting a display update.
- `busy`  out  1: high while a conversion is in progress; `load` is ignored while high.
- `overflow`  out  1: high when the last accepted value is ≥ 10^`digits`.
- `anode`  out  `digits`: active-low digit enables, one-hot-low.
- `segment`  out  8: active-low segments, bit order {dp,g,f,e,d,c,b,a}.

## Operation
Conversion FSM states:
- **IDLE**
  - `load`=1 captures `value` into the shift register and clears the BCD accumulator (4·`digits` bits).
  - If `value` ≥ 10^`digits` (localparam compare), go to COMMIT with the overflow flag set.
  - Otherwise go to CONVERT with the iteration counter = 0.
- **CONVERT**
  - Each cycle: add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
  - After `value_width` iterations, go to COMMIT.
- **COMMIT**
  - Copy the BCD accumulator (or an all-dash pattern on overflow) into the display register.
  - Update `overflow`, then go to IDLE.

Rules:
- `load` in any state other than IDLE is dropped. There is no queueing.
- The display register holds its value until the next COMMIT.

Scanner:
- Free-running counter 0..`digit_period`−1.
- At the terminal count, the digit index advances modulo `digits`, wrapping `digits`−1 → 0.
- `anode` = ~(1 << index), registered.

Segment decode:
- 0..9 use the standard glyphs; '0' = 8'hC0.
- Blank = 8'hFF. Dash = 8'hBF.
- dp is always off.
- Leading-zero blanking: zero nibbles above the most-significant non-zero digit are blanked. Digit 0 is never blanked.
- On overflow, every digit shows a dash.

## Timing
- **Reset asserted:**
  - `anode`=all ones, `segment`=8'hFF.
  - `busy`=0, `overflow`=0.
  - Display register=0, index=0, scan counter=0, FSM=IDLE.
- **First rising edge after reset release:** `anode`=…1110 and `segment`=8'hC0 (digit 0 shows '0').
- **Normal load:**
  - `load` sampled at edge t.
  - `busy`=1 from t+1 through t+`value_width`+1.
  - COMMIT occurs at t+`value_width`+1.
  - New digits and `overflow` are visible from t+`value_width`+2, when `busy`=0.
- **Overflow load:**
  - `busy`=1 at t+1 only.
  - Dashes and `overflow`=1 are visible from t+2.
- `segment` and `anode` change on the same edge, so there is no ghosting cycle.
- A COMMIT coinciding with a digit advance shows the new value on the new digit in that same cycle.
- A mid-conversion reset aborts immediately: all outputs take their reset values and the conversion is lost.
- `load` on the cycle `busy` falls (IDLE) is accepted.

## Structure
- Package `seven_segment_pkg` holds:
  - the FSM state enum (IDLE/CONVERT/COMMIT);
  - the glyph constants for 0–9, blank and dash;
  - the segment bit-order constant.
- Sub-module `binary_to_bcd` (parameters `value_width`, `digits`) contains:
  - the capture/shift/add-3 datapath, iteration counter and FSM;
  - the overflow compare;
  - the ports `start`, `busy`, `done`, `bcd`, `overflow`.
- The top level holds the display register, scanner, leading-zero blanking and glyph decode.

## Test plan
All benches run with `digit_period`=4.
- **Reset:** hold reset low for 10 cycles, then release → `anode`=4'b1111 and `segment`=8'hFF during reset; after release, digit 0 shows 8'hC0 and digits 1–3 are blank.
- **Normal load:** `load` with `value`=1234 → `busy` high for 15 cycles; scan yields nibbles 4,3,2,1 on anodes 1110,1101,1011,0111; `overflow`=0.
- **Leading-zero blanking:** `value`=7 → digit 0 shows 8'hF8 and digits 1–3 show 8'hFF; `value`=0 → digit 0 shows 8'hC0 only.
- **Overflow boundary:** `value`=10000 → `busy` for 1 cycle, all digits 8'hBF, `overflow`=1; then `value`=9999 → all digits show '9' (8'h90), `overflow`=0.
- **Load while busy:** `load` 42, then `load` 99 five cycles later → the second load is ignored and the display shows 42.
- **Reset mid-conversion:** assert reset at cycle 7 of CONVERT → immediate reset values; after release, the display shows '0' and `busy`=0.
